// File: rtl/lsu_pkg.sv
// Shared decode constants, FSM/size enums and lane helpers for the memory-stage LSU port.
package lsu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RSP  = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_e;

  function automatic logic [3:0] byte_enables(input mem_size_e sz, input logic [1:0] lo);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = 4'b0011 << {lo[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_replicate(input mem_size_e sz, input logic [31:0] wd);
    logic [31:0] r;
    case (sz)
      SZ_BYTE: r = {4{wd[7:0]}};
      SZ_HALF: r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load aligner: selects the addressed byte/half of the read word and extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte  = 8'h00;
    sel_half  = 16'h0000;
    load_data = 32'h0000_0000;
    case (addr_lo)
      2'b00:   sel_byte = rdata[7:0];
      2'b01:   sel_byte = rdata[15:8];
      2'b10:   sel_byte = rdata[23:16];
      default: sel_byte = rdata[31:24];
    endcase
    if (addr_lo[1]) begin
      sel_half = rdata[31:16];
    end else begin
      sel_half = rdata[15:0];
    end
    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_BU:   load_data = {24'h000000, sel_byte};
      F3_HU:   load_data = {16'h0000, sel_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu_port.sv
// Memory-stage load/store port: decodes the held instruction, runs one bus request/response and stalls the DE->MW register meanwhile.
// Build macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses pulse `misalign` instead of being force-aligned.
module mem_lsu_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       aluIn,
  input  logic [31:0]       writeDataIn,
  input  logic [31:0]       instIn,
  output logic              stall,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic              req_we,
  output logic [31:0]       req_wdata,
  output logic [3:0]        req_be,
  input  logic              rsp_valid,
  input  logic [31:0]       rsp_rdata,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              misalign
);

  lsu_state_e  state, state_next;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, mem_op, trap, start, stall_c;
  mem_size_e   size;
  logic [1:0]  addr_lo;
  logic [31:0] eff_addr;
  logic        load_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] aligned;
  logic        unused_bits;

  assign unused_bits = ^{instIn[31:15], instIn[11:7]};

  always_comb begin
    opcode   = instIn[6:0];
    funct3   = instIn[14:12];
    is_load  = 1'b0;
    is_store = 1'b0;
    if (opcode == OPC_LOAD) begin
      case (funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: is_load = 1'b1;
        default:                        is_load = 1'b0;
      endcase
    end else if (opcode == OPC_STORE) begin
      case (funct3)
        F3_B, F3_H, F3_W: is_store = 1'b1;
        default:          is_store = 1'b0;
      endcase
    end else begin
      is_load  = 1'b0;
      is_store = 1'b0;
    end
  end

  assign mem_op = is_load | is_store;

  // Size and force-aligned low address bits; the slave picks lanes from req_be.
  always_comb begin
    case (funct3[1:0])
      2'b00:   size = SZ_BYTE;
      2'b01:   size = SZ_HALF;
      default: size = SZ_WORD;
    endcase
    case (size)
      SZ_HALF: addr_lo = {aluIn[1], 1'b0};
      SZ_WORD: addr_lo = 2'b00;
      default: addr_lo = aluIn[1:0];
    endcase
    eff_addr = {aluIn[31:2], addr_lo};
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap     = mem_op && (((size == SZ_HALF) && aluIn[0]) ||
                               ((size == SZ_WORD) && (aluIn[1:0] != 2'b00)));
  assign misalign = !reset && (state == ST_IDLE) && trap;
`else
  assign trap     = 1'b0;
  assign misalign = 1'b0;
`endif

  assign start = mem_op && !trap;

  always_comb begin
    state_next = state;
    stall_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_REQ;
          stall_c    = 1'b1;
        end else begin
          state_next = ST_IDLE;
          stall_c    = 1'b0;
        end
      end
      ST_REQ: begin
        stall_c = 1'b1;
        if (req_ready) begin
          state_next = ST_RSP;
        end else begin
          state_next = ST_REQ;
        end
      end
      ST_RSP: begin
        stall_c = 1'b1;
        if (rsp_valid) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_RSP;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        stall_c    = 1'b0;
      end
      default: begin
        state_next = ST_IDLE;
        stall_c    = 1'b0;
      end
    endcase
  end

  // Reset gates the combinational IDLE stall so it clears in the same cycle.
  assign stall      = !reset && stall_c;
  assign req_valid  = (state == ST_REQ);
  assign load_valid = (state == ST_DONE) && load_q;

  lsu_load_align u_align (
    .rdata     (rsp_rdata),
    .addr_lo   (addr_lo_q),
    .funct3    (funct3_q),
    .load_data (aligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      req_addr  <= {ADDR_W{1'b0}};
      req_we    <= 1'b0;
      req_wdata <= 32'h0000_0000;
      req_be    <= 4'b0000;
      load_data <= 32'h0000_0000;
      load_q    <= 1'b0;
      funct3_q  <= 3'b000;
      addr_lo_q <= 2'b00;
    end else begin
      state <= state_next;
      if ((state == ST_IDLE) && start) begin
        req_addr  <= ADDR_W'(eff_addr);
        req_we    <= is_store;
        req_wdata <= lane_replicate(size, writeDataIn);
        req_be    <= byte_enables(size, addr_lo);
        load_q    <= is_load;
        funct3_q  <= funct3;
        addr_lo_q <= addr_lo;
      end
      if ((state == ST_RSP) && rsp_valid && load_q) begin
        load_data <= aligned;
      end
    end
  end

endmodule
